// File: rtl/inst_mem.sv
// Instruction memory with a loader write port, a registered fetch response and optional bad-address flagging (INST_MEM_ERR_EN).
// Latency: the response appears exactly 1 cycle after an accepted fetch.
// Backpressure: a response stalled by inst_ready=0 is held stable and blocks new fetches; flush drops it and blocks fetching.
module inst_mem #(
   parameter int                ADDR_W = 6,
   parameter int                DATA_W = 32,
   parameter int                PC_W   = 32,
   parameter logic [DATA_W-1:0] NOP    = {DATA_W{1'b0}}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fetch_req,
   input  logic [PC_W-1:0]   fetch_pc,
   output logic              fetch_ready,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [DATA_W-1:0] inst,
   output logic              inst_err,
   input  logic              flush,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data
);

   localparam int DEPTH = 2**ADDR_W;

   // Storage starts out filled with NOP; reset never touches it.
   logic [DATA_W-1:0] mem [DEPTH] = '{default: NOP};

   logic [ADDR_W-1:0] idx;
   logic              accept;
   logic              bad;

   // Word index drops the two byte-offset bits of the fetch address.
   assign idx         = fetch_pc[ADDR_W+1:2];
   assign fetch_ready = !rst && !flush && (!inst_valid || inst_ready);
   assign accept      = fetch_req && fetch_ready;

`ifdef INST_MEM_ERR_EN
   // Misaligned or out-of-range fetches are reported instead of wrapping.
   assign bad = (fetch_pc[1:0] != 2'b00) || ((fetch_pc >> (ADDR_W + 2)) != '0);

   // Error flag travels with the response and is held with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         inst_err <= 1'b0;
      end else if (accept) begin
         inst_err <= bad;
      end
   end
`else
   // Without error checking the offset and upper address bits are don't-care.
   logic unused_pc_bits;
   assign unused_pc_bits = ^fetch_pc;
   assign bad            = 1'b0;
   assign inst_err       = 1'b0;
`endif

   // Loader port writes regardless of reset, flush or fetch state.
   always_ff @(posedge clk) begin
      if (ld_en) begin
         mem[ld_addr] <= ld_data;
      end
   end

   // Response register: the read samples the old word on a same-edge loader write.
   always_ff @(posedge clk) begin
      if (rst) begin
         inst_valid <= 1'b0;
         inst       <= NOP;
      end else if (flush) begin
         inst_valid <= 1'b0;
      end else if (accept) begin
         inst_valid <= 1'b1;
         inst       <= bad ? NOP : mem[idx];
      end else if (inst_ready) begin
         inst_valid <= 1'b0;
      end
   end

endmodule
